activation_control: RTL and testbench
=====================================

# activation_control

Sequencer that sits upstream of the `activation` unit and drives it. It takes an instruction (accumulator start row, unified-buffer start row, row count, activation function, signedness) and issues one accumulator read per row. It presents `activation_function`/`is_signed` to the activation unit aligned with each row's data. It then emits unified-buffer write strobes and addresses aligned with the activation unit's byte output, tracking in-flight rows so back-to-back instructions overlap without corruption.

## Interface
Parameters:
- `ACC_ADDR_WIDTH`, default 9: accumulator row address width.
- `BUF_ADDR_WIDTH`, default 14: unified-buffer row address width.
- `LENGTH_WIDTH`, default 16: row-count width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, input, 1: clock.
  - `rst`, input, 1: synchronous, active-high reset.
- Stall:
  - `enable`, input, 1: global stall. Same signal as the activation unit's and accumulator read port's `enable`.
- Instruction channel:
  - `instr_valid`, input, 1: instruction present.
  - `instr_ready`, output, 1: controller can accept.
  - `instr_acc_addr`, input, `ACC_ADDR_WIDTH`: first accumulator row.
  - `instr_buf_addr`, input, `BUF_ADDR_WIDTH`: first unified-buffer row.
  - `instr_length`, input, `LENGTH_WIDTH`: number of rows; 0 is legal.
  - `instr_function`, input, `activation_type`: relu / sigmoid / no_activation.
  - `instr_signed`, input, 1: signed arithmetic.
- Accumulator read port:
  - `acc_read_en`, output, 1: accumulator read strobe.
  - `acc_read_addr`, output, `ACC_ADDR_WIDTH`: accumulator read address.
- Activation side-band:
  - `act_function`, output, `activation_type`: drives `activation_function`.
  - `act_is_signed`, output, 1: drives `is_signed`.
- Unified-buffer write port:
  - `buf_write_en`, output, 1: buffer write strobe.
  - `buf_write_addr`, output, `BUF_ADDR_WIDTH`: buffer write address.
- Status:
  - `busy`, output, 1: instruction issuing or rows in flight.
  - `done`, output, 1: one-cycle pulse marking instruction completion.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: `instr_ready`=1.
    - Accept (`instr_valid`&`instr_ready`&`enable`) with length>0: latch fields; go to ISSUE.
    - Accept with length=0: no reads; `done` pulses in the next enabled cycle; stay IDLE.
  - ISSUE: one read per enabled cycle. `acc_read_addr` = latched acc address + row index. Remaining count decrements. The read for the last row moves the FSM to DRAIN. `instr_ready`=0.
  - DRAIN: `instr_ready`=1; an accept follows the same rules as in IDLE. When the delay line is empty and nothing is accepted, go to IDLE.
- Delay line: 4 stages, advancing only when `enable`=1.
  - Each stage holds {valid, last, function, signed, buf_addr}.
  - Stage 0 is loaded with each issued read.
  - `act_function`/`act_is_signed` come from stage 0 (the cycle the accumulator data is on the activation input).
  - `buf_write_en`/`buf_write_addr` come from stage 3.
  - `done` = stage 3 valid&last, ORed with a pending zero-length completion.
- When stage 0 is invalid, `act_function`=no_activation and `act_is_signed`=0.
- Per-row function/signedness travel with the row, so overlapping instructions with different functions are each processed correctly.
- Address arithmetic wraps modulo 2^`ACC_ADDR_WIDTH` / 2^`BUF_ADDR_WIDTH`. Row index is `LENGTH_WIDTH` bits.
- `busy` = (state≠IDLE) | any delay-line valid.
- `enable`=0 holds:
  - all state, counters and delay line;
  - `acc_read_en`=0 and `buf_write_en`=0 that cycle.
  - All other outputs hold.
- Reset: state IDLE, all valids cleared.
  - `instr_ready`=0 during reset, 1 in the first cycle after.
  - `acc_read_en`, `buf_write_en`, `done`, `busy`, `act_is_signed` = 0.
  - `act_function` = no_activation.
  - Addresses = 0.
  - Reset mid-instruction aborts it: no further reads, writes or `done` from it.

## Timing
- Accept at edge of cycle a. Row i (0-based) is read in cycle a+1+i, assuming no stalls.
- Accumulator read latency is 1. Row i's data, `act_function` and `act_is_signed` are presented in cycle a+2+i.
- Activation latency is 3. Row i's `buf_write_en` falls in cycle a+5+i.
- `done` coincides with the last row's write, in cycle a+4+L.
- Each stall cycle shifts all of the above by one.
- Throughput: one row per enabled cycle, including across back-to-back instructions accepted in DRAIN.

## Test plan
- Single instruction: acc_addr=10, buf_addr=100, L=4, relu, signed, accepted at cycle 0.
  - Reads of rows 10..13 in cycles 1..4.
  - `act_function`=relu in cycles 2..5.
  - Writes to 100..103 in cycles 5..8.
  - `done` in cycle 8; `busy` low from cycle 9.
- Back-to-back: instruction A (L=3, sigmoid) followed by instruction B (L=2, no_activation, signed=0), with B accepted in DRAIN.
  - Reads are contiguous with no gap.
  - `act_function` switches from sigmoid to no_activation exactly at B's first row.
  - `done` pulses twice.
- Stall: L=5 with `enable`=0 in cycles 3 and 6.
  - Every read, write and `done` shifts by one cycle per stall.
  - No strobes occur during stalls.
- Wrap: acc_addr=2^ACC_ADDR_WIDTH−1, L=3.
  - Read addresses are max, 0, 1.
  - buf_addr=2^BUF_ADDR_WIDTH−2 gives write addresses max−1, max, 0.
- Zero length: accept with L=0.
  - No reads or writes.
  - `done` one cycle later; FSM remains IDLE.
- Reset mid-op: assert `rst` in cycle 3 of an L=8 instruction.
  - No strobes after reset.
  - `busy`=0 and `instr_ready`=1 in the cycle after `rst` deasserts.

Source files
------------

// File: rtl/activation_control.sv
// Row sequencer for the activation unit: issues accumulator reads, carries per-row
// side-band through a 4-stage delay line, and emits unified-buffer write strobes.

package activation_control_pkg;
  typedef enum logic [1:0] {
    no_activation = 2'd0,
    relu          = 2'd1,
    sigmoid       = 2'd2
  } activation_type;
endpackage

module activation_control
  import activation_control_pkg::*;
#(
  parameter int ACC_ADDR_WIDTH = 9,
  parameter int BUF_ADDR_WIDTH = 14,
  parameter int LENGTH_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr,
  input  logic [BUF_ADDR_WIDTH-1:0] instr_buf_addr,
  input  logic [LENGTH_WIDTH-1:0]   instr_length,
  input  activation_type            instr_function,
  input  logic                      instr_signed,
  output logic                      acc_read_en,
  output logic [ACC_ADDR_WIDTH-1:0] acc_read_addr,
  output activation_type            act_function,
  output logic                      act_is_signed,
  output logic                      buf_write_en,
  output logic [BUF_ADDR_WIDTH-1:0] buf_write_addr,
  output logic                      busy,
  output logic                      done
);

  // state | meaning
  // IDLE  | no instruction issuing, ready for a new one
  // ISSUE | rows remain to be loaded into the read register, not ready
  // DRAIN | last row issued, rows may be in flight, ready for the next instruction
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic                      valid;
    logic                      last;
    activation_type            func;
    logic                      is_signed;
    logic [BUF_ADDR_WIDTH-1:0] buf_addr;
  } row_t;

  state_t                    state;
  row_t                      rd_q;
  logic [ACC_ADDR_WIDTH-1:0] rd_addr_q;
  logic [ACC_ADDR_WIDTH-1:0] next_acc_q;
  logic [BUF_ADDR_WIDTH-1:0] next_buf_q;
  logic [LENGTH_WIDTH-1:0]   remaining_q;
  activation_type            func_q;
  logic                      signed_q;
  row_t                      line_q [4];
  logic                      zl_pending_q;

  logic accept;
  logic line_draining;

  assign instr_ready = ~rst & (state != ISSUE);
  assign accept      = instr_valid & instr_ready & enable;

  // Only stage 3 may still be occupied: it leaves the line on this edge.
  assign line_draining = ~rd_q.valid & ~line_q[0].valid & ~line_q[1].valid & ~line_q[2].valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_q         <= '0;
      rd_addr_q    <= '0;
      next_acc_q   <= '0;
      next_buf_q   <= '0;
      remaining_q  <= '0;
      func_q       <= no_activation;
      signed_q     <= 1'b0;
      zl_pending_q <= 1'b0;
      for (int i = 0; i < 4; i++) line_q[i] <= '0;
    end else if (enable) begin
      line_q[0] <= rd_q;
      for (int i = 1; i < 4; i++) line_q[i] <= line_q[i-1];
      zl_pending_q <= 1'b0;
      rd_q.valid   <= 1'b0;

      if (accept) begin
        if (instr_length == '0) begin
          zl_pending_q <= 1'b1;
        end else begin
          rd_q.valid     <= 1'b1;
          rd_q.last      <= (instr_length == LENGTH_WIDTH'(1));
          rd_q.func      <= instr_function;
          rd_q.is_signed <= instr_signed;
          rd_q.buf_addr  <= instr_buf_addr;
          rd_addr_q      <= instr_acc_addr;
          next_acc_q     <= instr_acc_addr + ACC_ADDR_WIDTH'(1);
          next_buf_q     <= instr_buf_addr + BUF_ADDR_WIDTH'(1);
          remaining_q    <= instr_length - LENGTH_WIDTH'(1);
          func_q         <= instr_function;
          signed_q       <= instr_signed;
          state          <= (instr_length == LENGTH_WIDTH'(1)) ? DRAIN : ISSUE;
        end
      end else begin
        case (state)
          ISSUE: begin
            rd_q.valid     <= 1'b1;
            rd_q.last      <= (remaining_q == LENGTH_WIDTH'(1));
            rd_q.func      <= func_q;
            rd_q.is_signed <= signed_q;
            rd_q.buf_addr  <= next_buf_q;
            rd_addr_q      <= next_acc_q;
            next_acc_q     <= next_acc_q + ACC_ADDR_WIDTH'(1);
            next_buf_q     <= next_buf_q + BUF_ADDR_WIDTH'(1);
            remaining_q    <= remaining_q - LENGTH_WIDTH'(1);
            if (remaining_q == LENGTH_WIDTH'(1)) state <= DRAIN;
          end
          DRAIN: begin
            if (line_draining) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign acc_read_en    = enable & ~rst & rd_q.valid;
  assign acc_read_addr  = rd_addr_q;
  assign act_function   = line_q[0].valid ? line_q[0].func : no_activation;
  assign act_is_signed  = line_q[0].valid & line_q[0].is_signed;
  assign buf_write_en   = enable & ~rst & line_q[3].valid;
  assign buf_write_addr = line_q[3].buf_addr;
  assign done           = enable & ~rst & ((line_q[3].valid & line_q[3].last) | zl_pending_q);
  assign busy           = (state != IDLE) | line_q[0].valid | line_q[1].valid |
                          line_q[2].valid | line_q[3].valid;

endmodule

// File: tb/tb_activation_control.sv
// Directed bench for activation_control: per-cycle event logs compared against
// hand-derived cycle/address tables for each scenario.

module tb_activation_control;
  import activation_control_pkg::*;

  logic           clk;
  logic           rst;
  logic           enable;
  logic           instr_valid;
  logic           instr_ready;
  logic [8:0]     instr_acc_addr;
  logic [13:0]    instr_buf_addr;
  logic [15:0]    instr_length;
  activation_type instr_function;
  logic           instr_signed;
  logic           acc_read_en;
  logic [8:0]     acc_read_addr;
  activation_type act_function;
  logic           act_is_signed;
  logic           buf_write_en;
  logic [13:0]    buf_write_addr;
  logic           busy;
  logic           done;

  activation_control #(
    .ACC_ADDR_WIDTH(9),
    .BUF_ADDR_WIDTH(14),
    .LENGTH_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_acc_addr(instr_acc_addr),
    .instr_buf_addr(instr_buf_addr),
    .instr_length(instr_length),
    .instr_function(instr_function),
    .instr_signed(instr_signed),
    .acc_read_en(acc_read_en),
    .acc_read_addr(acc_read_addr),
    .act_function(act_function),
    .act_is_signed(act_is_signed),
    .buf_write_en(buf_write_en),
    .buf_write_addr(buf_write_addr),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  int rd_n, wr_n, dn_n;
  int rd_c [16];
  int rd_a [16];
  int wr_c [16];
  int wr_a [16];
  int dn_c [16];
  int fn_log   [64];
  int sg_log   [64];
  int busy_log [64];
  int rdy_log  [64];
  int exp_c [8];
  int exp_a [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    cyc  = 0;
    rd_n = 0;
    wr_n = 0;
    dn_n = 0;
  endtask

  // One clock cycle: drive inputs just after the edge, sample just after that.
  task automatic tick(input logic v, input logic en, input logic r);
    @(posedge clk);
    #1;
    instr_valid = v;
    enable      = en;
    rst         = r;
    #1;
    if (acc_read_en && rd_n < 16) begin
      rd_c[rd_n] = cyc;
      rd_a[rd_n] = int'(acc_read_addr);
      rd_n++;
    end
    if (buf_write_en && wr_n < 16) begin
      wr_c[wr_n] = cyc;
      wr_a[wr_n] = int'(buf_write_addr);
      wr_n++;
    end
    if (done && dn_n < 16) begin
      dn_c[dn_n] = cyc;
      dn_n++;
    end
    if (cyc < 64) begin
      fn_log[cyc]   = int'(act_function);
      sg_log[cyc]   = int'(act_is_signed);
      busy_log[cyc] = int'(busy);
      rdy_log[cyc]  = int'(instr_ready);
    end
    cyc++;
  endtask

  task automatic check_events(input string tag, input int n_obs, input int oc[16],
                              input int oa[16], input int n_exp);
    check({tag, "_count"}, n_obs, n_exp);
    for (int i = 0; i < n_exp && i < n_obs; i++) begin
      check({tag, "_cycle"}, oc[i], exp_c[i]);
      check({tag, "_addr"}, oa[i], exp_a[i]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    enable = 1'b1;
    instr_valid = 1'b0;
    instr_acc_addr = '0;
    instr_buf_addr = '0;
    instr_length = '0;
    instr_function = no_activation;
    instr_signed = 1'b0;
    clear_logs();

    // reset state
    tick(0, 1, 1);
    tick(0, 1, 1);
    check("rst_ready", 32'(instr_ready), 0);
    check("rst_rd_en", 32'(acc_read_en), 0);
    check("rst_wr_en", 32'(buf_write_en), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_signed", 32'(act_is_signed), 0);
    check("rst_func", 32'(act_function), 32'(no_activation));
    check("rst_rd_addr", 32'(acc_read_addr), 0);
    check("rst_wr_addr", 32'(buf_write_addr), 0);
    tick(0, 1, 0);
    check("post_rst_ready", 32'(instr_ready), 1);

    // single instruction: acc 10, buf 100, L=4, relu, signed
    instr_acc_addr = 9'd10; instr_buf_addr = 14'd100; instr_length = 16'd4;
    instr_function = relu;  instr_signed = 1'b1;
    clear_logs();
    tick(1, 1, 0);
    repeat (11) tick(0, 1, 0);
    exp_c = '{1, 2, 3, 4, 0, 0, 0, 0};
    exp_a = '{10, 11, 12, 13, 0, 0, 0, 0};
    check_events("s1_rd", rd_n, rd_c, rd_a, 4);
    exp_c = '{5, 6, 7, 8, 0, 0, 0, 0};
    exp_a = '{100, 101, 102, 103, 0, 0, 0, 0};
    check_events("s1_wr", wr_n, wr_c, wr_a, 4);
    check("s1_done_count", dn_n, 1);
    check("s1_done_cycle", dn_c[0], 8);
    check("s1_fn_c1", fn_log[1], 32'(no_activation));
    check("s1_fn_c2", fn_log[2], 32'(relu));
    check("s1_fn_c5", fn_log[5], 32'(relu));
    check("s1_fn_c6", fn_log[6], 32'(no_activation));
    check("s1_sg_c2", sg_log[2], 1);
    check("s1_sg_c6", sg_log[6], 0);
    check("s1_busy_c0", busy_log[0], 0);
    check("s1_busy_c8", busy_log[8], 1);
    check("s1_busy_c9", busy_log[9], 0);
    check("s1_ready_c1", rdy_log[1], 0);
    check("s1_ready_c4", rdy_log[4], 1);

    // back-to-back: A (acc 20, buf 200, L=3, sigmoid, signed) then B in DRAIN
    instr_acc_addr = 9'd20; instr_buf_addr = 14'd200; instr_length = 16'd3;
    instr_function = sigmoid; instr_signed = 1'b1;
    clear_logs();
    tick(1, 1, 0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    instr_acc_addr = 9'd40; instr_buf_addr = 14'd300; instr_length = 16'd2;
    instr_function = no_activation; instr_signed = 1'b0;
    tick(1, 1, 0);
    repeat (9) tick(0, 1, 0);
    check("s2_ready_c3", rdy_log[3], 1);
    exp_c = '{1, 2, 3, 4, 5, 0, 0, 0};
    exp_a = '{20, 21, 22, 40, 41, 0, 0, 0};
    check_events("s2_rd", rd_n, rd_c, rd_a, 5);
    exp_c = '{5, 6, 7, 8, 9, 0, 0, 0};
    exp_a = '{200, 201, 202, 300, 301, 0, 0, 0};
    check_events("s2_wr", wr_n, wr_c, wr_a, 5);
    check("s2_done_count", dn_n, 2);
    check("s2_done0_cycle", dn_c[0], 7);
    check("s2_done1_cycle", dn_c[1], 9);
    check("s2_fn_c2", fn_log[2], 32'(sigmoid));
    check("s2_fn_c4", fn_log[4], 32'(sigmoid));
    check("s2_fn_c5", fn_log[5], 32'(no_activation));
    check("s2_sg_c4", sg_log[4], 1);
    check("s2_sg_c5", sg_log[5], 0);
    check("s2_busy_c9", busy_log[9], 1);
    check("s2_busy_c10", busy_log[10], 0);

    // stall: acc 50, buf 500, L=5, enable low in cycles 3 and 6
    instr_acc_addr = 9'd50; instr_buf_addr = 14'd500; instr_length = 16'd5;
    instr_function = relu;  instr_signed = 1'b0;
    clear_logs();
    tick(1, 1, 0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    repeat (7) tick(0, 1, 0);
    exp_c = '{1, 2, 4, 5, 7, 0, 0, 0};
    exp_a = '{50, 51, 52, 53, 54, 0, 0, 0};
    check_events("s3_rd", rd_n, rd_c, rd_a, 5);
    exp_c = '{7, 8, 9, 10, 11, 0, 0, 0};
    exp_a = '{500, 501, 502, 503, 504, 0, 0, 0};
    check_events("s3_wr", wr_n, wr_c, wr_a, 5);
    check("s3_done_count", dn_n, 1);
    check("s3_done_cycle", dn_c[0], 11);
    check("s3_fn_c3", fn_log[3], 32'(relu));
    check("s3_busy_c12", busy_log[12], 0);

    // address wrap on both ports
    instr_acc_addr = 9'd511; instr_buf_addr = 14'd16382; instr_length = 16'd3;
    instr_function = relu;   instr_signed = 1'b1;
    clear_logs();
    tick(1, 1, 0);
    repeat (9) tick(0, 1, 0);
    exp_c = '{1, 2, 3, 0, 0, 0, 0, 0};
    exp_a = '{511, 0, 1, 0, 0, 0, 0, 0};
    check_events("s4_rd", rd_n, rd_c, rd_a, 3);
    exp_c = '{5, 6, 7, 0, 0, 0, 0, 0};
    exp_a = '{16382, 16383, 0, 0, 0, 0, 0, 0};
    check_events("s4_wr", wr_n, wr_c, wr_a, 3);
    check("s4_done_cycle", dn_c[0], 7);

    // zero length
    instr_acc_addr = 9'd7; instr_buf_addr = 14'd9; instr_length = 16'd0;
    instr_function = sigmoid; instr_signed = 1'b1;
    clear_logs();
    tick(1, 1, 0);
    repeat (5) tick(0, 1, 0);
    check("s5_rd_count", rd_n, 0);
    check("s5_wr_count", wr_n, 0);
    check("s5_done_count", dn_n, 1);
    check("s5_done_cycle", dn_c[0], 1);
    check("s5_busy_c1", busy_log[1], 0);
    check("s5_ready_c1", rdy_log[1], 1);

    // reset in cycle 3 of an L=8 instruction
    instr_acc_addr = 9'd100; instr_buf_addr = 14'd1000; instr_length = 16'd8;
    instr_function = relu;   instr_signed = 1'b1;
    clear_logs();
    tick(1, 1, 0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(0, 1, 1);
    repeat (9) tick(0, 1, 0);
    exp_c = '{1, 2, 0, 0, 0, 0, 0, 0};
    exp_a = '{100, 101, 0, 0, 0, 0, 0, 0};
    check_events("s6_rd", rd_n, rd_c, rd_a, 2);
    check("s6_wr_count", wr_n, 0);
    check("s6_done_count", dn_n, 0);
    check("s6_ready_c3", rdy_log[3], 0);
    check("s6_busy_c4", busy_log[4], 0);
    check("s6_ready_c4", rdy_log[4], 1);
    check("s6_fn_c4", fn_log[4], 32'(no_activation));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
